// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch stage with a DEPTH-entry queue between the instruction
//   cache port and decode. It generates sequential fetch PCs, stops fetching
//   when the queue is full, and flushes and restarts on a redirect. It also
//   freezes fetch after it fetches a halt instruction.
//
// Ports
//   CLK          clock, rising edge
//   RST          synchronous, active-high reset
//   imem_ren     fetch request (never 1 while RST, redirect, full or halted)
//   imem_addr    fetch address (= fetch PC)
//   ihit         cache returns imem_load this cycle (ignored when imem_ren=0)
//   imem_load    fetched instruction word
//   redirect     flush the queue and restart fetch at redirect_pc
//   redirect_pc  restart address, word-aligned internally
//   out_valid    queue head valid
//   out_ready    decode accepts the head
//   out_instr    head instruction (0 when empty)
//   out_pc       head PC (0 when empty)
//   out_pp4      head PC+4 (0 when empty)
//   halted       halt instruction fetched, fetch frozen
//   count        current queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter logic [31:0] PC_INIT = 32'h0,
   parameter int          DEPTH   = 4,
   parameter logic [5:0]  HALT_OP = 6'b111111
) (
   input  logic                       CLK,
   input  logic                       RST,
   output logic                       imem_ren,
   output logic [31:0]                imem_addr,
   input  logic                       ihit,
   input  logic [31:0]                imem_load,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_pp4,
   output logic                       halted,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {S_FETCH, S_HALTED} state_e;

   state_e             state_q, state_d;
   logic [31:0]        fpc_q, fpc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [31:0]        instr_q [DEPTH];
   logic [31:0]        pc_q    [DEPTH];
   logic [31:0]        pp4_q   [DEPTH];

   logic full, empty, push, pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // Fetch request depends only on registered state plus RST/redirect, so a
   // pop never frees a slot for a push in the same cycle.
   assign imem_ren  = (state_q == S_FETCH) & ~full & ~redirect & ~RST;
   assign imem_addr = fpc_q;
   assign push      = imem_ren & ihit;
   assign pop       = ~empty & out_ready;

   // Head outputs come straight from the slot at rd_ptr, zeroed when empty.
   assign out_valid = ~empty;
   assign out_instr = empty ? 32'h0 : instr_q[rd_ptr_q];
   assign out_pc    = empty ? 32'h0 : pc_q[rd_ptr_q];
   assign out_pp4   = empty ? 32'h0 : pp4_q[rd_ptr_q];
   assign halted    = (state_q == S_HALTED);
   assign count     = count_q;

   always_comb begin
      // NOTE: every next-state value gets a default first so no path through
      // this block leaves a variable unassigned (which would infer a latch).
      state_d  = state_q;
      fpc_d    = fpc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (redirect) begin
         // Flush wins over push and pop; any hit this cycle is dropped.
         state_d  = S_FETCH;
         fpc_d    = {redirect_pc[31:2], 2'b00};
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            fpc_d    = fpc_q + 32'd4;
            if (imem_load[31:26] == HALT_OP) state_d = S_HALTED;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_FETCH;
         fpc_q    <= PC_INIT;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: queue storage is deliberately not reset; count/pointers gate every
   // read, so stale slot contents are never visible.
   always_ff @(posedge CLK) begin
      if (push) begin
         instr_q[wr_ptr_q] <= imem_load;
         pc_q[wr_ptr_q]    <= fpc_q;
         pp4_q[wr_ptr_q]   <= fpc_q + 32'd4;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int          DEPTH   = 4;
   localparam logic [31:0] PC_INIT = 32'h0;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imem_ren;
   logic [31:0] imem_addr;
   logic        ihit;
   logic [31:0] imem_load;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pp4;
   logic        halted;
   logic [2:0]  count;

   fetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH), .HALT_OP(6'b111111)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .imem_ren   (imem_ren),
      .imem_addr  (imem_addr),
      .ihit       (ihit),
      .imem_load  (imem_load),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .out_pp4    (out_pp4),
      .halted     (halted),
      .count      (count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pp4;
   } entry_t;

   entry_t      sb[$];
   logic [31:0] m_fpc;
   logic        m_halted;
   logic [31:0] halt_pc;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock cycle: inputs are already set (we sit at a falling edge).
   // Checks outputs against the model, then advances the model across the
   // next rising edge.
   task automatic step();
      logic   exp_ren, exp_valid;
      entry_t e;
      imem_load = (m_fpc == halt_pc) ? 32'hFC00_0000 : {8'hA5, m_fpc[23:0]};
      #1;
      exp_valid = (sb.size() != 0);
      exp_ren   = !RST && !m_halted && (sb.size() != DEPTH) && !redirect;
      check("imem_ren",  {31'h0, imem_ren},  {31'h0, exp_ren});
      check("imem_addr", imem_addr, m_fpc);
      check("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
      check("count",     {29'h0, count},     sb.size());
      check("halted",    {31'h0, halted},    {31'h0, m_halted});
      if (!exp_valid) begin
         check("bubble_instr", out_instr, 32'h0);
         check("bubble_pc",    out_pc,    32'h0);
         check("bubble_pp4",   out_pp4,   32'h0);
      end
      if (RST) begin
         m_fpc    = PC_INIT;
         m_halted = 1'b0;
         sb.delete();
      end else if (redirect) begin
         m_fpc    = {redirect_pc[31:2], 2'b00};
         m_halted = 1'b0;
         sb.delete();
      end else begin
         if (exp_valid && out_ready) begin
            e = sb.pop_front();
            check("head_instr", out_instr, e.instr);
            check("head_pc",    out_pc,    e.pc);
            check("head_pp4",   out_pp4,   e.pp4);
         end
         if (exp_ren && ihit) begin
            sb.push_back('{imem_load, m_fpc, m_fpc + 32'd4});
            if (imem_load[31:26] == 6'b111111) m_halted = 1'b1;
            m_fpc = m_fpc + 32'd4;
         end
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic drive(input logic r, input logic hit, input logic rdy,
                        input logic rdr, input logic [31:0] rpc, input int n);
      RST = r; ihit = hit; out_ready = rdy; redirect = rdr; redirect_pc = rpc;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; out_ready = 1'b0; redirect = 1'b0;
      redirect_pc = 32'h0; imem_load = 32'h0;
      m_fpc = PC_INIT; m_halted = 1'b0; halt_pc = 32'h1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);

      // Reset state, then streaming with ihit and out_ready held high.
      drive(1, 1, 1, 0, 32'h0, 1);
      drive(0, 1, 1, 0, 32'h0, 8);
      check("stream_count", {29'h0, count}, 32'd1);

      // Fill to full with decode stalled; fetch holds at 0x10.
      drive(0, 0, 0, 1, 32'h0, 1);
      drive(0, 1, 0, 0, 32'h0, 6);
      check("full_addr",  imem_addr, 32'h10);
      check("full_count", {29'h0, count}, 32'd4);
      drive(0, 1, 1, 0, 32'h0, 1);
      check("pulse_count", {29'h0, count}, 32'd3);
      drive(0, 1, 0, 0, 32'h0, 1);
      check("refill_count", {29'h0, count}, 32'd4);

      // Queue holding 0x20..0x2C, then redirect to 0x103 with a hit.
      drive(0, 0, 0, 1, 32'h20, 1);
      drive(0, 1, 0, 0, 32'h0, 5);
      drive(0, 1, 1, 1, 32'h103, 1);
      check("redir_addr",  imem_addr, 32'h100);
      check("redir_count", {29'h0, count}, 32'd0);
      drive(0, 1, 1, 0, 32'h0, 3);

      // Halt fetched at 0x8: fetch freezes, queue drains, redirect resumes.
      drive(0, 0, 0, 1, 32'h0, 1);
      halt_pc = 32'h8;
      drive(0, 1, 0, 0, 32'h0, 5);
      check("halt_flag",  {31'h0, halted}, 32'd1);
      check("halt_count", {29'h0, count}, 32'd3);
      drive(0, 1, 1, 0, 32'h0, 5);
      halt_pc = 32'h1;
      drive(0, 1, 1, 1, 32'h40, 1);
      check("resume_halted", {31'h0, halted}, 32'd0);
      check("resume_addr",   imem_addr, 32'h40);
      drive(0, 1, 1, 0, 32'h0, 3);

      // Push+pop at count 2 across the 32-bit PC wrap and pointer wrap.
      drive(0, 0, 0, 1, 32'hFFFF_FFF0, 1);
      drive(0, 1, 0, 0, 32'h0, 2);
      drive(0, 1, 1, 0, 32'h0, 10);
      check("wrap_count", {29'h0, count}, 32'd2);
      check("wrap_addr",  imem_addr, 32'h20);
      drive(0, 0, 1, 0, 32'h0, 3);

      // Reset with count 3, halted and redirect asserted together.
      drive(0, 0, 0, 1, 32'h200, 1);
      halt_pc = 32'h208;
      drive(0, 1, 0, 0, 32'h0, 3);
      check("pre_rst_halted", {31'h0, halted}, 32'd1);
      halt_pc = 32'h1;
      drive(1, 1, 1, 1, 32'h555, 1);
      drive(1, 1, 1, 0, 32'h0, 1);
      check("rst_addr",  imem_addr, PC_INIT);
      check("rst_count", {29'h0, count}, 32'd0);
      drive(0, 1, 1, 0, 32'h0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
